// File: rtl/lane_id_lock_tracker.sv
// Per-physical-lane alignment-marker lane-ID tracker: decodes the AM match mask, qualifies it over
// consecutive AMs to declare lock, and flags bad AMs. Optional macro: LANE_ID_MULTI_HOT_CHECK_EN.
module lane_id_lock_tracker #(
    parameter int unsigned NB_ONEHOT_ID = 20,
    parameter int unsigned NB_LANE_ID   = $clog2(NB_ONEHOT_ID),
    parameter int unsigned N_LOCK       = 2,
    parameter int unsigned N_UNLOCK     = 4,
    parameter int unsigned NB_ERR_CNT   = 8
) (
    input  logic                    i_clock,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [NB_ONEHOT_ID-1:0] i_match_mask,
    input  logic                    i_clear_err,
    output logic [NB_LANE_ID-1:0]   o_lane_id,
    output logic                    o_lock,
    output logic                    o_am_error,
    output logic                    o_id_change,
    output logic [NB_ERR_CNT-1:0]   o_err_count
);

    localparam int unsigned N_MAX  = (N_LOCK > N_UNLOCK) ? N_LOCK : N_UNLOCK;
    localparam int unsigned NB_CNT = $clog2(N_MAX + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CANDIDATE,
        ST_LOCKED
    } state_t;

    state_t              state;
    logic [NB_CNT-1:0]   cand_cnt;
    logic [NB_CNT-1:0]   bad_cnt;
    logic [NB_LANE_ID-1:0] dec_id;
    logic                dec_found;
    logic                mask_ok;
    logic                good_am;
    logic                bad_am;
    logic                same_id;

    always_comb begin
        dec_id    = '0;
        dec_found = 1'b0;
        for (int unsigned k = 0; k < NB_ONEHOT_ID; k++) begin
            if (i_match_mask[k] && !dec_found) begin
                dec_id    = NB_LANE_ID'(k);
                dec_found = 1'b1;
            end
        end
    end

`ifdef LANE_ID_MULTI_HOT_CHECK_EN
    // m & (m-1) is nonzero exactly when more than one bit is set
    assign mask_ok = dec_found && !(|(i_match_mask & (i_match_mask - NB_ONEHOT_ID'(1))));
`else
    assign mask_ok = dec_found;
`endif

    assign same_id = (dec_id == o_lane_id);
    assign good_am = i_valid && mask_ok;
    assign bad_am  = i_valid && (!mask_ok || (state == ST_LOCKED && !same_id));

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_UNLOCKED;
            cand_cnt    <= '0;
            bad_cnt     <= '0;
            o_lane_id   <= '0;
            o_lock      <= 1'b0;
            o_am_error  <= 1'b0;
            o_id_change <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_am_error  <= bad_am;
            o_id_change <= 1'b0;

            if (i_valid) begin
                case (state)
                    ST_UNLOCKED: begin
                        if (good_am) begin
                            o_lane_id   <= dec_id;
                            o_id_change <= !same_id;
                            cand_cnt    <= NB_CNT'(1);
                            if (N_LOCK == 1) begin
                                state  <= ST_LOCKED;
                                o_lock <= 1'b1;
                            end else begin
                                state <= ST_CANDIDATE;
                            end
                        end
                    end
                    ST_CANDIDATE: begin
                        if (!good_am) begin
                            state    <= ST_UNLOCKED;
                            cand_cnt <= '0;
                        end else if (same_id) begin
                            cand_cnt <= cand_cnt + NB_CNT'(1);
                            if (cand_cnt == NB_CNT'(N_LOCK - 1)) begin
                                state  <= ST_LOCKED;
                                o_lock <= 1'b1;
                            end
                        end else begin
                            o_lane_id   <= dec_id;
                            o_id_change <= 1'b1;
                            cand_cnt    <= NB_CNT'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!bad_am) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == NB_CNT'(N_UNLOCK - 1)) begin
                            state    <= ST_UNLOCKED;
                            o_lock   <= 1'b0;
                            bad_cnt  <= '0;
                            cand_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + NB_CNT'(1);
                        end
                    end
                    default: begin
                        state <= ST_UNLOCKED;
                    end
                endcase
            end

            if (i_clear_err) begin
                o_err_count <= '0;
            end else if (bad_am && (o_err_count != '1)) begin
                o_err_count <= o_err_count + NB_ERR_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_lane_id_lock_tracker.sv
// Self-checking bench for lane_id_lock_tracker: directed scenarios plus randomized AM traffic,
// compared cycle by cycle against a behavioural lock-qualification model.
module tb_lane_id_lock_tracker;

    localparam int N_LOCK   = 2;
    localparam int N_UNLOCK = 4;
    localparam int ERR_MAX  = 255;

    logic        i_clock = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [19:0] i_match_mask = '0;
    logic        i_clear_err = 1'b0;
    logic [4:0]  o_lane_id;
    logic        o_lock;
    logic        o_am_error;
    logic        o_id_change;
    logic [7:0]  o_err_count;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit m_locked;
    int m_run;      // consecutive matching AMs while not locked (0 = no candidate)
    int m_bad;      // consecutive bad AMs while locked
    int m_id;
    int m_err;
    bit m_am_err;
    bit m_idc;

    lane_id_lock_tracker #(
        .NB_ONEHOT_ID(20),
        .N_LOCK(N_LOCK),
        .N_UNLOCK(N_UNLOCK),
        .NB_ERR_CNT(8)
    ) dut (
        .i_clock(i_clock),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .i_match_mask(i_match_mask),
        .i_clear_err(i_clear_err),
        .o_lane_id(o_lane_id),
        .o_lock(o_lock),
        .o_am_error(o_am_error),
        .o_id_change(o_id_change),
        .o_err_count(o_err_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        check("lane_id",   int'(o_lane_id),   m_id);
        check("lock",      int'(o_lock),      int'(m_locked));
        check("am_error",  int'(o_am_error),  int'(m_am_err));
        check("id_change", int'(o_id_change), int'(m_idc));
        check("err_count", int'(o_err_count), m_err);
    endtask

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_bad = 0; m_id = 0; m_err = 0;
        m_am_err = 0; m_idc = 0;
    endtask

    function automatic bit mask_usable(input bit [19:0] m);
`ifdef LANE_ID_MULTI_HOT_CHECK_EN
        return $countones(m) == 1;
`else
        return m != 0;
`endif
    endfunction

    function automatic int lowest_index(input bit [19:0] m);
        bit [19:0] iso;
        iso = m & (~m + 20'd1);
        return $clog2(iso);
    endfunction

    task automatic model_step(input bit v, input bit [19:0] m, input bit clr);
        bit ok;
        int id;
        ok = mask_usable(m);
        id = ok ? lowest_index(m) : -1;
        m_am_err = 0;
        m_idc = 0;
        if (v) begin
            if (m_locked) begin
                if (ok && id == m_id) m_bad = 0;
                else begin
                    m_am_err = 1;
                    m_bad++;
                    if (m_bad == N_UNLOCK) begin
                        m_locked = 0; m_bad = 0; m_run = 0;
                    end
                end
            end else if (!ok) begin
                m_am_err = 1;
                m_run = 0;
            end else if (m_run > 0 && id == m_id) begin
                m_run++;
                if (m_run >= N_LOCK) m_locked = 1;
            end else begin
                m_idc = (id != m_id);
                m_id = id;
                m_run = 1;
                if (N_LOCK == 1) m_locked = 1;
            end
        end
        if (clr) m_err = 0;
        else if (m_am_err && m_err < ERR_MAX) m_err++;
    endtask

    task automatic cycle(input bit v, input bit [19:0] m, input bit clr);
        i_valid = v;
        i_match_mask = m;
        i_clear_err = clr;
        @(posedge i_clock);
        model_step(v, m, clr);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        @(negedge i_clock);
        i_rst_n = 0;
        i_valid = 0;
        i_match_mask = '0;
        i_clear_err = 0;
        model_reset();
        #1;
        check_all();
        @(negedge i_clock);
        i_rst_n = 1;
    endtask

    initial begin
        bit [19:0] rmask;
        int pick;
        model_reset();
        #12;
        check_all();
        @(negedge i_clock);
        i_rst_n = 1;

        // lock on ID 3
        cycle(1, 20'h00008, 0);
        cycle(1, 20'h00008, 0);
        cycle(0, 20'h00000, 0);
        // four zero masks unlock, ID held
        repeat (4) cycle(1, 20'h00000, 0);
        cycle(0, 20'h00000, 0);

        // bad run interrupted by one good AM keeps lock
        apply_reset();
        repeat (2) cycle(1, 20'h00008, 0);
        repeat (3) cycle(1, 20'h00000, 0);
        cycle(1, 20'h00008, 0);
        repeat (3) cycle(1, 20'h00000, 0);

        // candidate restart to ID 19
        apply_reset();
        cycle(1, 20'h00020, 0);
        cycle(1, 20'h80000, 0);
        cycle(1, 20'h80000, 0);

        // multi-hot handling
        apply_reset();
        cycle(1, 20'h00003, 0);
        cycle(1, 20'h00003, 0);

        // error counter saturation, then clear beats a simultaneous bad AM
        apply_reset();
        repeat (260) cycle(1, 20'h00000, 0);
        cycle(1, 20'h00000, 1);
        cycle(1, 20'h00000, 0);

        // asynchronous reset mid-candidate
        apply_reset();
        cycle(1, 20'h00020, 0);
        #3;
        i_rst_n = 0;
        model_reset();
        #1;
        check_all();
        @(negedge i_clock);
        i_rst_n = 1;
        i_valid = 0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 25)      rmask = '0;
            else if (pick < 70) begin
                case ($urandom_range(0, 2))
                    0: rmask = 20'h00008;
                    1: rmask = 20'h00020;
                    default: rmask = 20'h80000;
                endcase
            end else if (pick < 85) rmask = 20'h00008 | (20'h1 << $urandom_range(4, 19));
            else                    rmask = 20'($urandom);
            cycle($urandom_range(0, 3) != 0, rmask, $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_id_lock_tracker.md
Name: lane_id_lock_tracker

Overview:
- Per-physical-lane alignment-marker (AM) lane-ID tracker; parametrised successor to the combinational one-hot → binary lane-ID decoder.
- Decodes the AM comparator match mask on each AM slot and qualifies the result over consecutive AMs.
- Declares a PCS-lane lock and flags AM errors and lane-ID changes.
- One instance per physical lane, between the AM comparators and the lane reorder/deskew logic.

Parameters:
- NB_ONEHOT_ID, 20, number of PCS lanes = width of match mask.
- NB_LANE_ID, $clog2(NB_ONEHOT_ID), width of decoded lane ID.
- N_LOCK, 2, consecutive matching AMs with identical ID required to lock (≥1).
- N_UNLOCK, 4, consecutive bad AMs while locked required to unlock (≥1).
- NB_ERR_CNT, 8, width of saturating bad-AM counter.

Ports:
- i_clock  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  AM slot strobe; mask sampled only when high.
- i_match_mask  in  NB_ONEHOT_ID  AM comparator hits, bit k = matches lane k AM.
- i_clear_err  in  1  synchronous clear of o_err_count.
- o_lane_id  out  NB_LANE_ID  locked/candidate lane ID.
- o_lock  out  1  lane ID locked.
- o_am_error  out  1  one-cycle pulse: bad AM seen.
- o_id_change  out  1  one-cycle pulse: o_lane_id updated to a different value.
- o_err_count  out  NB_ERR_CNT  saturating count of bad AMs.

Behaviour:
- Decode (combinational): lowest set bit index wins; mask all-zero → "no match".
- "Good AM": i_valid=1 and mask nonzero.
- "Bad AM":
  - i_valid=1 and mask zero; or
  - in LOCKED, decoded ID ≠ o_lane_id.
- Cycles with i_valid=0 change nothing.
- Outputs are registered; latency 1 cycle from i_valid to outputs.
- Reset (async, i_rst_n=0): state=UNLOCKED, candidate count=0, bad count=0, o_lane_id=0, o_lock=0, o_am_error=0, o_id_change=0, o_err_count=0. Reset mid-sequence discards all progress.
- FSM states:
  - UNLOCKED:
    - good AM → latch candidate ID into o_lane_id, cnt=1.
    - If N_LOCK==1 → LOCKED, else → CANDIDATE.
    - Bad AM → stay, pulse o_am_error.
  - CANDIDATE:
    - Good AM, same ID → cnt+1; cnt reaching N_LOCK → LOCKED, o_lock=1 on the next edge.
    - Good AM, different ID → restart with new ID, cnt=1, pulse o_id_change, no o_am_error.
    - Zero mask → UNLOCKED, cnt=0, pulse o_am_error.
  - LOCKED:
    - Good AM with same ID → bad cnt=0.
    - Bad AM → bad cnt+1, pulse o_am_error; bad cnt reaching N_UNLOCK → UNLOCKED, o_lock=0, bad cnt=0.
    - o_lane_id holds until relock.
- o_id_change asserts only when the registered o_lane_id value differs from its previous value.
- o_err_count increments on every o_am_error and saturates at 2^NB_ERR_CNT−1.
  - i_clear_err forces 0.
  - i_clear_err together with a bad AM in the same cycle → 0 (clear wins).
- Counters are sized $clog2(max(N_LOCK,N_UNLOCK)+1); no wrap possible.

Optional Feature:
- Macro: LANE_ID_MULTI_HOT_CHECK_EN.
- Defined: a mask with more than one bit set is treated as a zero mask (bad AM) in every state.
- Undefined: multi-hot masks are decoded by lowest-index priority and treated as good.

Test Plan:
- Reset, then i_valid pulses with mask=20'h00008 twice (N_LOCK=2) → o_lane_id=3 after first, o_lock=1 one cycle after second, o_id_change pulse once, o_am_error never.
- Locked on ID 3, then 4 AMs with mask=0 → o_am_error pulses 4×, o_lock=0 after 4th, o_err_count=4, o_lane_id stays 3.
- Locked on ID 3, then 3 bad AMs, one good mask=20'h00008, 3 bad → o_lock stays 1 (counter reset by good AM), o_err_count=6.
- CANDIDATE with ID 5, then mask=20'h80000 → o_lane_id=19, o_id_change pulse, o_lock=0; a second 20'h80000 → o_lock=1.
- Multi-hot mask=20'h00003 twice: with LANE_ID_MULTI_HOT_CHECK_EN → two o_am_error pulses, no lock; without → lock on ID 0.
- Drive o_err_count to 255 → holds 255; i_clear_err asserted in the same cycle as a bad AM → 0. Assert i_rst_n=0 asynchronously mid-CANDIDATE → all outputs 0 immediately.
